// File: rtl/mm_job_sequencer.sv
// mm_job_sequencer: buffers host operands, launches and feeds the multiplier, then
// captures its result stream and serves it back through a show-ahead read port.
module mm_job_sequencer #(
  parameter int DW    = 8,
  parameter int RW    = 16,
  parameter int N_OP  = 12,
  parameter int N_RES = 4,
  parameter int LAT   = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          start,
  output logic          cf_load,
  output logic [DW-1:0] din,
  input  logic [RW-1:0] dout,
  output logic          rd_valid,
  output logic [RW-1:0] rd_data,
  input  logic          rd_en,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          err_clr
);
  localparam int MX  = (N_OP > LAT) ? ((N_OP > N_RES) ? N_OP : N_RES) : ((LAT > N_RES) ? LAT : N_RES);
  localparam int CW  = $clog2(MX + 1);
  localparam int OCW = $clog2(N_OP + 1);
  localparam int OPW = (N_OP > 1) ? $clog2(N_OP) : 1;
  localparam int RPW = (N_RES > 1) ? $clog2(N_RES) : 1;
  localparam int RCW = $clog2(N_RES + 1);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_STREAM, S_WAIT, S_CAPTURE, S_DRAIN} state_t;
  state_t         state_q, state_d;
  logic [OCW-1:0] op_cnt_q, op_cnt_d;
  logic [CW-1:0]  cnt_q, cnt_d, nxt;
  logic [RCW-1:0] res_cnt_q, res_cnt_d;
  logic [RPW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]  din_q, din_d;
  logic           cf_load_q, cf_load_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic           op_we, res_we, err_ev;
  logic [DW-1:0]  op_buf_q [N_OP];
  logic [RW-1:0]  res_buf_q [N_RES];
  assign wr_ready = (state_q == S_IDLE) && (op_cnt_q < OCW'(N_OP));
  assign rd_valid = (state_q == S_DRAIN) && (res_cnt_q != '0);
  assign rd_data  = res_buf_q[rd_ptr_q];
  assign cf_load  = cf_load_q;
  assign din      = din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  always_comb begin
    state_d   = state_q;
    op_cnt_d  = op_cnt_q;
    cnt_d     = cnt_q;
    res_cnt_d = res_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    din_d     = '0;
    cf_load_d = 1'b0;
    done_d    = 1'b0;
    res_we    = 1'b0;
    nxt       = cnt_q + CW'(1);
    op_we     = wr_en && wr_ready;
    // start is judged against the count before any same-cycle write
    err_ev    = (wr_en && !wr_ready) || (start && state_q == S_IDLE && op_cnt_q != OCW'(N_OP));
    err_d     = err_ev ? 1'b1 : err_clr ? 1'b0 : err_q;
    case (state_q)
      S_IDLE: begin
        if (op_we) op_cnt_d = op_cnt_q + OCW'(1);
        if (start && op_cnt_q == OCW'(N_OP)) begin
          state_d   = S_LAUNCH;
          cf_load_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_STREAM;
        cnt_d   = '0;
        din_d   = op_buf_q[0];
      end
      S_STREAM: begin
        if (cnt_q == CW'(N_OP - 1)) begin
          state_d = S_WAIT;
          cnt_d   = CW'(LAT - 1);
        end else begin
          cnt_d = nxt;
          din_d = op_buf_q[nxt[OPW-1:0]];
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else cnt_d = cnt_q - CW'(1);
      end
      S_CAPTURE: begin
        res_we = 1'b1;
        if (cnt_q == CW'(N_RES - 1)) begin
          state_d   = S_DRAIN;
          res_cnt_d = RCW'(N_RES);
          rd_ptr_d  = '0;
        end else cnt_d = nxt;
      end
      S_DRAIN: begin
        if (rd_en && res_cnt_q != '0) begin
          rd_ptr_d  = (rd_ptr_q == RPW'(N_RES - 1)) ? '0 : rd_ptr_q + RPW'(1);
          res_cnt_d = res_cnt_q - RCW'(1);
          if (res_cnt_q == RCW'(1)) begin
            state_d  = S_IDLE;
            op_cnt_d = '0;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_cnt_q  <= '0;
      cnt_q     <= '0;
      res_cnt_q <= '0;
      rd_ptr_q  <= '0;
      din_q     <= '0;
      cf_load_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_cnt_q  <= op_cnt_d;
      cnt_q     <= cnt_d;
      res_cnt_q <= res_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      din_q     <= din_d;
      cf_load_q <= cf_load_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end
  // buffers carry no reset; their contents are meaningless until written
  always_ff @(posedge clk) begin
    if (op_we) op_buf_q[op_cnt_q[OPW-1:0]] <= wr_data;
    if (res_we) res_buf_q[cnt_q[RPW-1:0]] <= dout;
  end
endmodule

// File: tb/tb_mm_job_sequencer.sv
// tb_mm_job_sequencer: scenario tasks with a queue scoreboard for operands and results.
module tb_mm_job_sequencer;
  logic        clk = 0, reset_n = 0, wr_en = 0, start = 0, rd_en = 0, err_clr = 0;
  logic [7:0]  wr_data = 0;
  logic        wr_ready, cf_load, rd_valid, busy, done, err;
  logic [7:0]  din;
  logic [15:0] dout, rd_data;
  int          cyc = 0, lc = 0, checks = 0, failures = 0;
  logic [7:0]  exp_din [$];
  logic [15:0] exp_res [$];

  mm_job_sequencer dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .cf_load(cf_load), .din(din), .dout(dout), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_en(rd_en), .busy(busy), .done(done), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign dout = 16'h1000 + 16'(cyc - lc);

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_ops(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; wr_data = base + 8'(i);
      exp_din.push_back(base + 8'(i));
      tick;
    end
    wr_en = 0;
  endtask

  task automatic clear_err;
    err_clr = 1; tick; err_clr = 0;
  endtask

  task automatic run_job(input int wr_at, input int st_at, input int hold);
    int n;
    logic [15:0] e, prev;
    start = 1; tick; start = 0;
    checks++;
    if ({cf_load, busy} !== 2'b11) begin failures++; $display("FAIL launch cf_load,busy got=%b exp=11", {cf_load, busy}); end
    lc = cyc;
    for (int j = 0; j < 4; j++) exp_res.push_back(16'h1000 + 16'(27 + j));
    tick;
    for (int i = 0; i < 12; i++) begin
      e = {8'h00, exp_din.pop_front()};
      checks++;
      if ({cf_load, din} !== {1'b0, e[7:0]}) begin failures++; $display("FAIL stream[%0d] cf_load,din got=%b,%h exp=0,%h", i, cf_load, din, e[7:0]); end
      wr_en = (i == wr_at); wr_data = 8'hEE; start = (i == st_at);
      tick;
      wr_en = 0; start = 0;
    end
    checks++;
    if (din !== 8'h00) begin failures++; $display("FAIL wait_din got=%h exp=00", din); end
    n = 0;
    while (!rd_valid && n < 40) begin tick; n++; end
    checks++;
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL rd_valid_timeout got=%b exp=1", rd_valid); end
    for (int h = 0; h < hold; h++) begin
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, exp_res[0]}) begin failures++; $display("FAIL drain_hold[%0d] rd_data got=%h exp=%h", h, rd_data, exp_res[0]); end
      tick;
    end
    rd_en = 1;
    for (int j = 0; j < 4; j++) begin
      e = exp_res.pop_front();
      checks++;
      if (rd_data !== e) begin failures++; $display("FAIL result[%0d] got=%h exp=%h", j, rd_data, e); end
      tick;
    end
    checks++;
    if ({done, rd_valid, busy, wr_ready} !== 4'b1001) begin failures++; $display("FAIL drain_end done,rd_valid,busy,wr_ready got=%b exp=1001", {done, rd_valid, busy, wr_ready}); end
    prev = rd_data;
    tick;
    checks++;
    if ({done, rd_valid, rd_data} !== {2'b00, prev}) begin failures++; $display("FAIL post_pop done,rd_valid,rd_data got=%b,%b,%h exp=0,0,%h", done, rd_valid, rd_data, prev); end
    rd_en = 0;
  endtask

  task automatic test_reset;
    reset_n = 0; tick; tick; reset_n = 1; tick;
    checks++;
    if ({cf_load, din, busy, done, err, rd_valid, wr_ready} !== 14'b0_00000000_00001) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", {cf_load, din, busy, done, err, rd_valid, wr_ready}, 14'b0_00000000_00001);
    end
  endtask

  task automatic test_basic_job;
    write_ops(8'h01, 12);
    run_job(-1, 5, 0);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL busy_start_err got=%b exp=0", err); end
  endtask

  task automatic test_start_errors;
    write_ops(8'h21, 11);
    start = 1; tick; start = 0;
    checks++;
    if ({cf_load, busy, err} !== 3'b001) begin failures++; $display("FAIL short_start cf_load,busy,err got=%b exp=001", {cf_load, busy, err}); end
    clear_err;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", err); end
    wr_en = 1; wr_data = 8'h2C; start = 1; exp_din.push_back(8'h2C);
    tick; wr_en = 0; start = 0;
    checks++;
    if ({cf_load, err, wr_ready} !== 3'b010) begin failures++; $display("FAIL wr_start cf_load,err,wr_ready got=%b exp=010", {cf_load, err, wr_ready}); end
    clear_err;
    run_job(-1, -1, 0);
  endtask

  task automatic test_dropped_writes;
    write_ops(8'h31, 12);
    wr_en = 1; wr_data = 8'h99; tick; wr_en = 0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL full_write_err got=%b exp=1", err); end
    err_clr = 1; wr_en = 1; wr_data = 8'h98; tick; err_clr = 0; wr_en = 0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_wins got=%b exp=1", err); end
    clear_err;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clr2 got=%b exp=0", err); end
    run_job(3, -1, 0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL stream_write_err got=%b exp=1", err); end
    clear_err;
  endtask

  task automatic test_reset_midjob;
    write_ops(8'h41, 12);
    start = 1; tick; start = 0;
    repeat (14) tick;
    exp_din.delete();
    reset_n = 0; #1;
    checks++;
    if ({cf_load, din, busy, done, err, rd_valid, wr_ready} !== 14'b0_00000000_00001) begin
      failures++; $display("FAIL wait_reset got=%b exp=%b", {cf_load, din, busy, done, err, rd_valid, wr_ready}, 14'b0_00000000_00001);
    end
    #2 reset_n = 1; tick;
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL post_reset_wr_ready got=%b exp=1", wr_ready); end
    start = 1; tick; start = 0;
    checks++;
    if ({cf_load, err} !== 2'b01) begin failures++; $display("FAIL empty_start cf_load,err got=%b exp=01", {cf_load, err}); end
    clear_err;
    write_ops(8'h51, 12);
    start = 1; tick; start = 0;
    checks++;
    if (cf_load !== 1'b1) begin failures++; $display("FAIL launch2 cf_load got=%b exp=1", cf_load); end
    reset_n = 0; #1;
    checks++;
    if ({cf_load, busy} !== 2'b00) begin failures++; $display("FAIL launch_reset cf_load,busy got=%b exp=00", {cf_load, busy}); end
    #2 reset_n = 1; tick;
    exp_din.delete();
    exp_res.delete();
  endtask

  task automatic test_drain_hold;
    write_ops(8'h61, 12);
    run_job(-1, -1, 5);
  endtask

  initial begin
    test_reset;
    test_basic_job;
    test_start_errors;
    test_dropped_writes;
    test_reset_midjob;
    test_drain_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mm_job_sequencer.md
Name: mm_job_sequencer

Overview:
- Host-side sequencer that drives the matrix-multiply datapath.
- Buffers N_OP operand words written by the host, then issues a one-cycle cf_load launch pulse and streams the operands one per cycle on din.
- After a fixed pipeline latency, captures N_RES consecutive result words from dout and hands them back to the host through a show-ahead read port.
- It is the initiator/feeder for the multiplier controller's load sequence and the receiver for its serialized result stream.

Parameters:
DW, 8, operand width
RW, 16, result width
N_OP, 12, operands per job
N_RES, 4, result words per job
LAT, 14, cycles from the last STREAM cycle to the first CAPTURE cycle (minimum 1)

Ports:
clk  in  1  single clock; all state changes on rising edge
reset_n  in  1  asynchronous reset, active-low
wr_en  in  1  host operand write strobe
wr_data  in  DW  host operand
wr_ready  out  1  high when state=IDLE and op_cnt<N_OP
start  in  1  job start request
cf_load  out  1  launch pulse to multiplier controller
din  out  DW  operand stream to multiplier
dout  in  RW  result stream from multiplier
rd_valid  out  1  result buffer non-empty
rd_data  out  RW  current head result (show-ahead)
rd_en  in  1  pop head result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last result is popped
err  out  1  sticky protocol error flag
err_clr  in  1  clears err

Behaviour:
- Reset (asynchronous, on reset_n low): state=IDLE, op_cnt=0, res_cnt=0, rd_ptr=0, cf_load=0, din=0, done=0, err=0, busy=0, rd_valid=0. Buffer contents are don't-care. Reset asserted mid-job aborts immediately; cf_load drops the same instant.
- All outputs are registered except wr_ready, rd_valid and rd_data, which decode from registered state.
- IDLE:
  - wr_en with wr_ready stores wr_data into op_buf[op_cnt] and increments op_cnt.
  - start with op_cnt==N_OP moves to LAUNCH.
- LAUNCH (1 cycle): cf_load=1, din=0. Always moves to STREAM.
- STREAM (N_OP cycles): din=op_buf[i] for i=0..N_OP-1 on consecutive cycles; cf_load=0. The last cycle moves to WAIT.
- WAIT (LAT cycles): din=0; a down-counter is loaded with LAT on entry. Moves to CAPTURE when the counter expires.
- CAPTURE (N_RES cycles):
  - res_buf[j]=dout is sampled on each rising edge, j=0..N_RES-1.
  - The last cycle sets res_cnt=N_RES, rd_ptr=0 and moves to DRAIN.
- DRAIN:
  - rd_valid=1 while res_cnt>0; rd_data=res_buf[rd_ptr].
  - rd_en pops the head: rd_ptr+1, res_cnt-1.
  - The pop that reaches res_cnt==0 returns to IDLE with op_cnt=0, and done=1 for the following cycle.
- Timing: launch-to-first-operand = 1 cycle; cf_load to first capture = 1+N_OP+LAT cycles (27 at defaults). din and cf_load change on the rising edge and are stable at the multiplier's falling-edge sampling.
- Boundary conditions:
  - wr_en when op_cnt==N_OP in IDLE: write dropped, err=1.
  - wr_en outside IDLE: write dropped, err=1.
  - start in IDLE with op_cnt<N_OP: ignored, err=1. The check uses the pre-write count, so wr_en+start together at op_cnt=N_OP-1 stores the word but does not start, and sets err.
  - start while busy: ignored, no error.
  - rd_en when rd_valid=0: ignored, no error; rd_data holds.
  - err_clr together with a new error event: err stays 1 (error wins).
  - res_buf is written only in CAPTURE; rd_data is stable throughout DRAIN except on a pop.
  - op_buf is retained after a job; it is not re-zeroed, but op_cnt=0 forces a full refill before the next start.

Test Plan:
- Reset, write 12 operands 0x01..0x0C, pulse start:
  - cf_load high exactly 1 cycle;
  - din = 0x01..0x0C on the next 12 cycles;
  - busy high from the cycle after start.
- Drive dout = 0x1000+k at cycle k after launch: res_buf captures 0x101B, 0x101C, 0x101D, 0x101E (cycles 27..30). Pop 4 times with rd_en held high:
  - rd_data sequence matches;
  - done pulses once;
  - state returns to IDLE; wr_ready=1.
- Write 11 operands, pulse start:
  - no cf_load;
  - err=1.
  - err_clr clears err.
  - Then wr_en+start on the same cycle with the 12th word: word stored, no start, err=1.
  - A subsequent start launches.
- Write a 13th word in IDLE, and a word during STREAM: both dropped, err=1, streamed din values unchanged.
- Assert reset_n low during WAIT:
  - all outputs are at reset values immediately;
  - after release, wr_ready=1 and op_cnt=0;
  - start without writes sets err.
- In DRAIN, idle 5 cycles with rd_en=0 then pop:
  - rd_data holds 0x101B until the pop;
  - rd_en with rd_valid=0 after the final pop has no effect.
